// File: rtl/rf_port_sched_pkg.sv
// Shared definitions for the register-file port scheduler: widths, state encoding
// and the address/data types used on the scheduler interface.
package rf_port_sched_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

  // The state names the operation driven onto the register file this cycle.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10
  } state_t;

endpackage

// File: rtl/rf_port_sched_if.sv
// Requester and register-file command signals of the port scheduler.
// master = requesters plus register-file observer, slave = the scheduler itself.
interface rf_port_sched_if;
  import rf_port_sched_pkg::*;

  logic  RD_REQ;
  addr_t RD_ADDR1;
  addr_t RD_ADDR2;
  logic  RD_GNT;
  logic  RD_DATA_VALID;

  logic  WB0_REQ;
  addr_t WB0_ADDR;
  data_t WB0_DATA;
  logic  WB0_GNT;

  logic  WB1_REQ;
  addr_t WB1_ADDR;
  data_t WB1_DATA;
  logic  WB1_GNT;

  logic  RF_READ;
  logic  RF_WRITE;
  addr_t RF_ADDR_R1;
  addr_t RF_ADDR_R2;
  addr_t RF_ADDR_W;
  data_t RF_DATA_W;

  modport master (
    output RD_REQ, RD_ADDR1, RD_ADDR2,
    output WB0_REQ, WB0_ADDR, WB0_DATA,
    output WB1_REQ, WB1_ADDR, WB1_DATA,
    input  RD_GNT, RD_DATA_VALID, WB0_GNT, WB1_GNT,
    input  RF_READ, RF_WRITE, RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W, RF_DATA_W
  );

  modport slave (
    input  RD_REQ, RD_ADDR1, RD_ADDR2,
    input  WB0_REQ, WB0_ADDR, WB0_DATA,
    input  WB1_REQ, WB1_ADDR, WB1_DATA,
    output RD_GNT, RD_DATA_VALID, WB0_GNT, WB1_GNT,
    output RF_READ, RF_WRITE, RF_ADDR_R1, RF_ADDR_R2, RF_ADDR_W, RF_DATA_W
  );

endinterface

// File: rtl/rf_wb_rr_arb.sv
// Two-requester round-robin arbiter for the write-back ports. GNT is the write
// candidate; the pointer only moves when the caller reports the write was taken (ADV).
module rf_wb_rr_arb (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] REQ,
  input  logic       ADV,
  output logic [1:0] GNT
);

  // Source preferred on contention: 0 = WB0, 1 = WB1.
  logic ptr_q;

  always_comb begin
    GNT = REQ;
    if (REQ == 2'b11) begin
      GNT = ptr_q ? 2'b10 : 2'b01;
    end
  end

  // After a granted write the other source becomes preferred.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q <= 1'b0;
    end else if (ADV) begin
      ptr_q <= GNT[0];
    end
  end

endmodule

// File: rtl/rf_port_sched.sv
// Schedules one register-file operation per cycle between a read requester and two
// write-back requesters, with RAW ordering, write round-robin and bounded read starvation.
module rf_port_sched
  import rf_port_sched_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input logic            CLK,
  input logic            RST,
  rf_port_sched_if.slave rf
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] starve_q;
  logic [1:0]       wb_req;
  logic [1:0]       wb_cand;
  logic [1:0]       wb_gnt;
  logic             rd_gnt;
  logic             raw_hazard;
  logic             starved;

  assign wb_req = {rf.WB1_REQ, rf.WB0_REQ};

  rf_wb_rr_arb u_wb_arb (
    .CLK (CLK),
    .RST (RST),
    .REQ (wb_req),
    .ADV (|wb_gnt),
    .GNT (wb_cand)
  );

  // A pending write to either read address must land before the read is issued.
  assign raw_hazard = rf.RD_REQ &&
    ((rf.WB0_REQ && (rf.RD_ADDR1 == rf.WB0_ADDR || rf.RD_ADDR2 == rf.WB0_ADDR)) ||
     (rf.WB1_REQ && (rf.RD_ADDR1 == rf.WB1_ADDR || rf.RD_ADDR2 == rf.WB1_ADDR)));

  assign starved = (starve_q >= LIMIT);

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = ST_IDLE;
    rd_gnt  = 1'b0;
    wb_gnt  = 2'b00;
    if (!RST) begin
      if (raw_hazard) begin
        wb_gnt = wb_cand;
      end else if (rf.RD_REQ && starved) begin
        rd_gnt = 1'b1;
      end else if (|wb_cand) begin
        wb_gnt = wb_cand;
      end else if (rf.RD_REQ) begin
        rd_gnt = 1'b1;
      end
    end
    if (rd_gnt) begin
      state_d = ST_READ;
    end else if (|wb_gnt) begin
      state_d = ST_WRITE;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      starve_q <= '0;
    end else if (!rf.RD_REQ || rd_gnt) begin
      starve_q <= '0;
    end else if (starve_q < LIMIT) begin
      starve_q <= starve_q + CNT_W'(1);
    end
  end

  // Command registers hold their last values while the other operation is issued.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rf.RF_ADDR_R1 <= '0;
      rf.RF_ADDR_R2 <= '0;
      rf.RF_ADDR_W  <= '0;
      rf.RF_DATA_W  <= '0;
    end else begin
      if (rd_gnt) begin
        rf.RF_ADDR_R1 <= rf.RD_ADDR1;
        rf.RF_ADDR_R2 <= rf.RD_ADDR2;
      end
      if (wb_gnt[0]) begin
        rf.RF_ADDR_W <= rf.WB0_ADDR;
        rf.RF_DATA_W <= rf.WB0_DATA;
      end else if (wb_gnt[1]) begin
        rf.RF_ADDR_W <= rf.WB1_ADDR;
        rf.RF_DATA_W <= rf.WB1_DATA;
      end
    end
  end

  assign rf.RD_GNT        = rd_gnt;
  assign rf.WB0_GNT       = wb_gnt[0];
  assign rf.WB1_GNT       = wb_gnt[1];
  assign rf.RF_READ       = (state_q == ST_READ);
  assign rf.RF_WRITE      = (state_q == ST_WRITE);
  assign rf.RD_DATA_VALID = (state_q == ST_READ);

endmodule

// File: tb/tb_rf_port_sched.sv
// Bench for rf_port_sched: directed scenarios plus random traffic, all checked every
// cycle against a rule-level reference model and a behavioural 32x32 register file.
module tb_rf_port_sched;
  import rf_port_sched_pkg::*;

  localparam int LIMIT = 4;

  logic CLK = 1'b0;
  logic RST;

  rf_port_sched_if bus();

  rf_port_sched #(
    .STARVE_LIMIT (LIMIT),
    .CNT_W        (4)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .rf  (bus)
  );

  always #5 CLK = ~CLK;

  // Register file: written at the end of a WRITE cycle, read ports float outside READ.
  data_t mem [32] = '{default: '0};
  int    w13 = 0;
  data_t data_r1;
  data_t data_r2;

  assign data_r1 = bus.RF_READ ? mem[bus.RF_ADDR_R1] : 'z;
  assign data_r2 = bus.RF_READ ? mem[bus.RF_ADDR_R2] : 'z;

  always @(posedge CLK) begin
    if (bus.RF_WRITE) begin
      mem[bus.RF_ADDR_W] <= bus.RF_DATA_W;
      if (bus.RF_ADDR_W == 5'd13) w13 <= w13 + 1;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Winner from the arbitration rules: 0 none, 1 read, 2 WB0, 3 WB1.
  function automatic int ref_winner(input bit rd, input bit w0, input bit w1,
                                    input addr_t a1, input addr_t a2,
                                    input addr_t wa0, input addr_t wa1,
                                    input int wait_cnt, input int next_wb);
    int  wb;
    bit  hazard;
    wb = -1;
    if (w0 && w1) wb = next_wb;
    else if (w0)  wb = 0;
    else if (w1)  wb = 1;
    hazard = rd && ((w0 && (a1 == wa0 || a2 == wa0)) || (w1 && (a1 == wa1 || a2 == wa1)));
    if (hazard)                     return 2 + wb;
    if (rd && wait_cnt >= LIMIT)    return 1;
    if (wb >= 0)                    return 2 + wb;
    if (rd)                         return 1;
    return 0;
  endfunction

  // Observations shared with the stimulus process.
  int    cyc = 0;
  int    rd_gnt_cyc = -100;
  int    wb1_gnt_cyc = -100;
  data_t last_rd1 = '0;
  data_t last_rd2 = '0;
  bit    g_rd = 1'b0;
  bit    g0 = 1'b0;
  bit    g1 = 1'b0;
  int    wr_hist [$];

  // Monitor and reference model, evaluated mid-cycle on the falling edge.
  initial begin
    bit    exp_read, exp_write;
    addr_t exp_a1, exp_a2, exp_aw;
    data_t exp_dw, exp_rd1, exp_rd2;
    data_t ref_mem [32];
    int    wait_cnt, next_wb, win;
    exp_read = 0; exp_write = 0;
    exp_a1 = '0; exp_a2 = '0; exp_aw = '0; exp_dw = '0;
    exp_rd1 = '0; exp_rd2 = '0;
    wait_cnt = 0; next_wb = 0;
    for (int i = 0; i < 32; i++) ref_mem[i] = '0;
    forever begin
      @(negedge CLK);
      cyc++;
      check("rf_read",  bus.RF_READ,       exp_read);
      check("rf_write", bus.RF_WRITE,      exp_write);
      check("rd_valid", bus.RD_DATA_VALID, exp_read);
      check("addr_r1",  bus.RF_ADDR_R1,    exp_a1);
      check("addr_r2",  bus.RF_ADDR_R2,    exp_a2);
      check("addr_w",   bus.RF_ADDR_W,     exp_aw);
      check("data_w",   bus.RF_DATA_W,     exp_dw);
      if (exp_read) begin
        check("rd_data1", data_r1, exp_rd1);
        check("rd_data2", data_r2, exp_rd2);
        last_rd1 = data_r1;
        last_rd2 = data_r2;
      end

      win = RST ? 0 : ref_winner(bus.RD_REQ, bus.WB0_REQ, bus.WB1_REQ, bus.RD_ADDR1,
                                 bus.RD_ADDR2, bus.WB0_ADDR, bus.WB1_ADDR, wait_cnt, next_wb);
      check("rd_gnt",  bus.RD_GNT,  win == 1);
      check("wb0_gnt", bus.WB0_GNT, win == 2);
      check("wb1_gnt", bus.WB1_GNT, win == 3);

      g_rd = bus.RD_GNT;
      g0   = bus.WB0_GNT;
      g1   = bus.WB1_GNT;
      if (bus.RD_GNT)  rd_gnt_cyc = cyc;
      if (bus.WB1_GNT) wb1_gnt_cyc = cyc;
      if (bus.WB0_GNT) wr_hist.push_back(0);
      if (bus.WB1_GNT) wr_hist.push_back(1);

      if (RST) begin
        exp_read = 0; exp_write = 0;
        exp_a1 = '0; exp_a2 = '0; exp_aw = '0; exp_dw = '0;
        wait_cnt = 0; next_wb = 0;
      end else begin
        exp_read  = (win == 1);
        exp_write = (win >= 2);
        case (win)
          1: begin
            exp_a1  = bus.RD_ADDR1;
            exp_a2  = bus.RD_ADDR2;
            exp_rd1 = ref_mem[bus.RD_ADDR1];
            exp_rd2 = ref_mem[bus.RD_ADDR2];
          end
          2: begin
            exp_aw = bus.WB0_ADDR;
            exp_dw = bus.WB0_DATA;
            ref_mem[bus.WB0_ADDR] = bus.WB0_DATA;
            next_wb = 1;
          end
          3: begin
            exp_aw = bus.WB1_ADDR;
            exp_dw = bus.WB1_DATA;
            ref_mem[bus.WB1_ADDR] = bus.WB1_DATA;
            next_wb = 0;
          end
          default: ;
        endcase
        if (bus.RD_REQ && win != 1) wait_cnt = (wait_cnt < LIMIT) ? wait_cnt + 1 : LIMIT;
        else                        wait_cnt = 0;
      end
    end
  end

  // One clock step; requesters drop a request only after it has been granted.
  task automatic tick();
    @(posedge CLK);
    #1;
    if (g_rd) bus.RD_REQ  = 1'b0;
    if (g0)   bus.WB0_REQ = 1'b0;
    if (g1)   bus.WB1_REQ = 1'b0;
  endtask

  task automatic set_rd(input addr_t a1, input addr_t a2);
    bus.RD_REQ = 1'b1; bus.RD_ADDR1 = a1; bus.RD_ADDR2 = a2;
  endtask

  task automatic set_wb0(input addr_t a, input data_t d);
    bus.WB0_REQ = 1'b1; bus.WB0_ADDR = a; bus.WB0_DATA = d;
  endtask

  task automatic set_wb1(input addr_t a, input data_t d);
    bus.WB1_REQ = 1'b1; bus.WB1_ADDR = a; bus.WB1_DATA = d;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  // Wait for all pending requests to be served, then let the last command complete.
  task automatic drain();
    for (int k = 0; k < 64 && (bus.RD_REQ || bus.WB0_REQ || bus.WB1_REQ); k++) tick();
    check("drain_idle", {bus.RD_REQ, bus.WB0_REQ, bus.WB1_REQ}, 3'b000);
    tick();
    tick();
  endtask

  initial begin
    int    s;
    int    h0;
    int    base13;
    data_t d;

    RST = 1'b1;
    bus.RD_REQ = 1'b0;  bus.RD_ADDR1 = '0; bus.RD_ADDR2 = '0;
    bus.WB0_REQ = 1'b0; bus.WB0_ADDR = '0; bus.WB0_DATA = '0;
    bus.WB1_REQ = 1'b0; bus.WB1_ADDR = '0; bus.WB1_DATA = '0;
    tick();
    tick();
    RST = 1'b0;

    // Write then read of the same register: read granted the cycle after the write grant.
    s = cyc + 1;
    set_wb0(5'd5, 32'hDEAD_BEEF);
    tick();
    check("t1_rf_write", bus.RF_WRITE, 1'b1);
    set_rd(5'd5, 5'd0);
    drain();
    check("t1_rd_lat", rd_gnt_cyc - s, 1);
    check("t1_data", last_rd1, 32'hDEAD_BEEF);

    // Continuous contention between WB0 and WB1 alternates, WB0 first after reset.
    do_reset();
    h0 = wr_hist.size();
    set_wb0(5'd3, $urandom());
    set_wb1(5'd4, $urandom());
    repeat (8) begin
      tick();
      if (!bus.WB0_REQ) set_wb0(5'd3, $urandom());
      if (!bus.WB1_REQ) set_wb1(5'd4, $urandom());
    end
    drain();
    check("t2_count", wr_hist.size() - h0 >= 6, 1'b1);
    for (int i = 0; i < 6 && h0 + i < wr_hist.size(); i++)
      check($sformatf("t2_order%0d", i), wr_hist[h0 + i], i % 2);

    // Starved read wins on its 5th waiting cycle, twice in a row.
    s = cyc + 1;
    set_rd(5'd9, 5'd9);
    set_wb0(5'd10, $urandom());
    set_wb1(5'd11, $urandom());
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 20 && bus.RD_REQ; k++) begin
        tick();
        if (!bus.WB0_REQ) set_wb0(5'd10, $urandom());
        if (!bus.WB1_REQ) set_wb1(5'd11, $urandom());
      end
      check($sformatf("t3_wait%0d", r), rd_gnt_cyc - s + 1, LIMIT + 1);
      if (r == 0) begin
        s = cyc + 1;
        set_rd(5'd9, 5'd9);
      end
    end
    drain();

    // RAW hold with the starvation counter saturated.
    s = cyc + 1;
    set_rd(5'd9, 5'd7);
    set_wb0(5'd10, $urandom());
    repeat (3) begin
      tick();
      if (!bus.WB0_REQ) set_wb0(5'd10, $urandom());
    end
    tick();
    d = $urandom();
    set_wb1(5'd7, d);
    drain();
    check("t4_wb1_cyc", wb1_gnt_cyc - s, 4);
    check("t4_rd_cyc", rd_gnt_cyc - s, 5);
    check("t4_data", last_rd2, d);

    // Reset during a WRITE cycle with WB0 pending.
    set_wb1(5'd12, $urandom());
    tick();
    RST = 1'b1;
    d = $urandom();
    set_wb0(5'd13, d);
    base13 = w13;
    h0 = wr_hist.size();
    tick();
    RST = 1'b0;
    check("t5_rf_write", bus.RF_WRITE, 1'b0);
    check("t5_rf_read", bus.RF_READ, 1'b0);
    drain();
    check("t5_writes", w13 - base13, 1);
    check("t5_hist_n", wr_hist.size() - h0, 1);
    if (wr_hist.size() > h0) check("t5_first", wr_hist[h0], 0);

    // Idle: no command on the register file.
    repeat (10) begin
      tick();
      check("t6_valid", bus.RD_DATA_VALID, 1'b0);
      check("t6_rf_read", bus.RF_READ, 1'b0);
      check("t6_rf_write", bus.RF_WRITE, 1'b0);
    end

    // Random traffic over a small address range, with occasional resets.
    for (int n = 0; n < 2000; n++) begin
      tick();
      RST = ($urandom_range(0, 249) == 0);
      if (!bus.RD_REQ && $urandom_range(0, 1) == 1)
        set_rd(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      if (!bus.WB0_REQ && $urandom_range(0, 1) == 1)
        set_wb0(5'($urandom_range(0, 7)), $urandom());
      if (!bus.WB1_REQ && $urandom_range(0, 1) == 1)
        set_wb1(5'($urandom_range(0, 7)), $urandom());
    end
    tick();
    RST = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
